// File: rtl/dp_pkg.sv
// Shared parameters and state encoding for the DP feed controller.
package dp_pkg;

  localparam int unsigned BP_W   = 2;
  localparam int unsigned N      = 64;
  localparam int unsigned LOG_N  = 6;
  localparam int unsigned TLEN_W = 16;
  localparam int unsigned SLEN_W = LOG_N + 1;

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StLoadS   = 3'd1;
  localparam logic [2:0] StSync    = 3'd2;
  localparam logic [2:0] StStreamT = 3'd3;
  localparam logic [2:0] StDrain   = 3'd4;

endpackage

// File: rtl/dp_beat_counter.sv
// Beat counter with synchronous clear, enable and terminal-count compare.
module dp_beat_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             reset_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [Width-1:0] last_i,
  output logic             tc_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  // Clear has priority over counting.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // High while the current beat is the last one of the phase.
  assign tc_o = (cnt_q == last_i);

endmodule

// File: rtl/dp_feed_ctrl.sv
// Job sequencer feeding query and target bases into the DP systolic array.
module dp_feed_ctrl
  import dp_pkg::*;
(
  input  logic              clk,
  input  logic              reset_i,
  input  logic              job_start,
  input  logic [SLEN_W-1:0] job_s_len,
  input  logic [TLEN_W-1:0] job_t_len,
  output logic              job_ready,
  output logic              job_done,
  output logic              job_err,
  input  logic              abort,
  input  logic [BP_W-1:0]   bp_data,
  input  logic              bp_valid,
  output logic              bp_ready,
  output logic [BP_W-1:0]   S,
  output logic              s_update,
  output logic [LOG_N-1:0]  PE_end,
  output logic              new_seq,
  output logic [BP_W-1:0]   T,
  output logic              valid,
  input  logic              busy,
  output logic              ack,
  input  logic              tb_busy
);

  logic [2:0]        state_q, state_d;
  logic [TLEN_W-1:0] t_len_q, t_len_d;
  logic [LOG_N-1:0]  pe_end_q, pe_end_d;
  logic [BP_W-1:0]   s_q, s_d, t_q, t_d;
  logic              s_update_q, s_update_d, valid_q, valid_d;
  logic              new_seq_q, new_seq_d, ack_q, ack_d;
  logic              job_done_q, job_done_d, job_err_q, job_err_d;
  logic              beat;
  logic              s_clr, s_en, s_tc, t_clr, t_en, t_tc;

  // Stream ready depends only on phase and, for the target, on DP backpressure.
  always_comb begin
    bp_ready = 1'b0;
    unique case (state_q)
      StLoadS:   bp_ready = 1'b1;
      StStreamT: bp_ready = ~busy;
      default:   bp_ready = 1'b0;
    endcase
  end

  assign beat = bp_valid & bp_ready;

  // Next-state and output-register logic; abort overrides everything.
  always_comb begin
    state_d    = state_q;
    t_len_d    = t_len_q;
    pe_end_d   = pe_end_q;
    s_d        = s_q;
    t_d        = t_q;
    s_update_d = 1'b0;
    valid_d    = 1'b0;
    new_seq_d  = 1'b0;
    ack_d      = 1'b0;
    job_done_d = 1'b0;
    job_err_d  = 1'b0;
    s_clr      = 1'b0;
    s_en       = 1'b0;
    t_clr      = 1'b0;
    t_en       = 1'b0;
    if (abort) begin
      state_d = StIdle;
      s_clr   = 1'b1;
      t_clr   = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          s_clr = 1'b1;
          t_clr = 1'b1;
          if (job_start) begin
            t_len_d  = job_t_len;
            pe_end_d = LOG_N'(job_s_len - SLEN_W'(1));
            if (job_s_len == '0 || job_s_len > SLEN_W'(N)) begin
              job_err_d = 1'b1;
            end else begin
              state_d = StLoadS;
            end
          end
        end
        StLoadS: begin
          if (beat) begin
            s_d        = bp_data;
            s_update_d = 1'b1;
            s_en       = 1'b1;
            if (s_tc) state_d = StSync;
          end
        end
        StSync: begin
          // Traceback must be idle before the DP ping-pong buffers swap.
          if (!tb_busy) begin
            new_seq_d = 1'b1;
            state_d   = (t_len_q == '0) ? StDrain : StStreamT;
          end
        end
        StStreamT: begin
          if (beat) begin
            t_d     = bp_data;
            valid_d = 1'b1;
            t_en    = 1'b1;
            if (t_tc) state_d = StDrain;
          end
        end
        StDrain: begin
          if (!busy && !valid_q) begin
            ack_d      = 1'b1;
            job_done_d = 1'b1;
            state_d    = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      state_q    <= StIdle;
      t_len_q    <= '0;
      pe_end_q   <= '0;
      s_q        <= '0;
      t_q        <= '0;
      s_update_q <= 1'b0;
      valid_q    <= 1'b0;
      new_seq_q  <= 1'b0;
      ack_q      <= 1'b0;
      job_done_q <= 1'b0;
      job_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      t_len_q    <= t_len_d;
      pe_end_q   <= pe_end_d;
      s_q        <= s_d;
      t_q        <= t_d;
      s_update_q <= s_update_d;
      valid_q    <= valid_d;
      new_seq_q  <= new_seq_d;
      ack_q      <= ack_d;
      job_done_q <= job_done_d;
      job_err_q  <= job_err_d;
    end
  end

  dp_beat_counter #(
    .Width (LOG_N)
  ) u_s_cnt (
    .clk     (clk),
    .reset_i (reset_i),
    .clr_i   (s_clr),
    .en_i    (s_en),
    .last_i  (pe_end_q),
    .tc_o    (s_tc)
  );

  // Only reached with t_len >= 1, so t_len-1 never underflows here.
  dp_beat_counter #(
    .Width (TLEN_W)
  ) u_t_cnt (
    .clk     (clk),
    .reset_i (reset_i),
    .clr_i   (t_clr),
    .en_i    (t_en),
    .last_i  (t_len_q - TLEN_W'(1)),
    .tc_o    (t_tc)
  );

  assign job_ready = (state_q == StIdle);
  assign job_done  = job_done_q;
  assign job_err   = job_err_q;
  assign S         = s_q;
  assign s_update  = s_update_q;
  assign PE_end    = pe_end_q;
  assign new_seq   = new_seq_q;
  assign T         = t_q;
  assign valid     = valid_q;
  assign ack       = ack_q;

endmodule

// File: tb/tb_dp_feed_ctrl.sv
// Scoreboard bench for dp_feed_ctrl: host driver pushes expectations, monitor pops on strobes.
module tb_dp_feed_ctrl;
  import dp_pkg::*;

  logic              clk = 1'b0;
  logic              reset_i = 1'b0;
  logic              job_start = 1'b0;
  logic [SLEN_W-1:0] job_s_len = '0;
  logic [TLEN_W-1:0] job_t_len = '0;
  logic              job_ready, job_done, job_err;
  logic              abort = 1'b0;
  logic [BP_W-1:0]   bp_data = '0;
  logic              bp_valid = 1'b0;
  logic              bp_ready;
  logic [BP_W-1:0]   S, T;
  logic              s_update, new_seq, valid, ack;
  logic [LOG_N-1:0]  PE_end;
  logic              busy = 1'b0;
  logic              tb_busy = 1'b0;

  dp_feed_ctrl dut (
    .clk       (clk),
    .reset_i   (reset_i),
    .job_start (job_start),
    .job_s_len (job_s_len),
    .job_t_len (job_t_len),
    .job_ready (job_ready),
    .job_done  (job_done),
    .job_err   (job_err),
    .abort     (abort),
    .bp_data   (bp_data),
    .bp_valid  (bp_valid),
    .bp_ready  (bp_ready),
    .S         (S),
    .s_update  (s_update),
    .PE_end    (PE_end),
    .new_seq   (new_seq),
    .T         (T),
    .valid     (valid),
    .busy      (busy),
    .ack       (ack),
    .tb_busy   (tb_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [BP_W-1:0]  s_exp[$];
  logic [BP_W-1:0]  t_exp[$];
  logic [LOG_N-1:0] pe_exp[$];
  int ns_cnt = 0, ack_cnt = 0, done_cnt = 0, err_cnt = 0;
  int exp_ns = 0, exp_done = 0, exp_err = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pop and compare whenever the DUT presents a strobe.
  always @(negedge clk) begin
    if (reset_i) begin
      if (s_update) begin
        chk("s_update_expected", s_exp.size() > 0, 1);
        if (s_exp.size() > 0) chk("S_data", S, s_exp.pop_front());
      end
      if (valid) begin
        chk("valid_expected", t_exp.size() > 0, 1);
        if (t_exp.size() > 0) chk("T_data", T, t_exp.pop_front());
      end
      if (new_seq) begin
        ns_cnt++;
        chk("new_seq_expected", pe_exp.size() > 0, 1);
        if (pe_exp.size() > 0) chk("PE_end", PE_end, pe_exp.pop_front());
      end
      if (ack || job_done) begin
        chk("ack_with_job_done", ack, job_done);
        ack_cnt  += int'(ack);
        done_cnt += int'(job_done);
      end
      if (job_err) err_cnt++;
    end
  end

  // Host: issue a job request for one cycle.
  task automatic start_job(input int slen, input int tlen);
    chk("job_ready_before_start", job_ready, 1);
    job_start = 1'b1;
    job_s_len = SLEN_W'(slen);
    job_t_len = TLEN_W'(tlen);
    if (slen >= 1 && slen <= int'(N)) begin
      pe_exp.push_back(LOG_N'(slen - 1));
      exp_ns++;
    end else begin
      exp_err++;
    end
    @(posedge clk); #1;
    job_start = 1'b0;
  endtask

  // Host: deliver n beats with optional valid gaps and busy toggling.
  task automatic send_beats(input int n, input bit is_t, input bit gaps, input bit tog);
    int i = 0;
    int guard = 0;
    bit acc;
    while (i < n && guard < 4000) begin
      bp_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      bp_data  = gaps ? BP_W'($urandom) : BP_W'(i);
      if (tog) busy = ((cyc / 3) % 2) == 1;
      @(negedge clk);
      acc = bp_valid && bp_ready;
      if (is_t && busy) chk("bp_ready_low_while_busy", bp_ready, 0);
      @(posedge clk); #1;
      if (acc) begin
        if (is_t) t_exp.push_back(bp_data);
        else      s_exp.push_back(bp_data);
        i++;
      end
      guard++;
    end
    chk("beats_delivered", i, n);
    bp_valid = 1'b0;
    if (tog) busy = 1'b0;
  endtask

  task automatic wait_done();
    int g = 0;
    while (done_cnt < exp_done && g < 300) begin
      @(posedge clk); #1;
      g++;
    end
    chk("job_done_count", done_cnt, exp_done);
    chk("ack_count", ack_cnt, exp_done);
    chk("new_seq_count", ns_cnt, exp_ns);
    chk("s_queue_drained", s_exp.size(), 0);
    chk("t_queue_drained", t_exp.size(), 0);
  endtask

  // Complete legal job; tbb_hold keeps tb_busy high in SYNC, drain_busy holds busy in DRAIN.
  task automatic run_job(input int slen, input int tlen, input bit gaps, input bit tog,
                         input int tbb_hold, input int drain_busy);
    if (tbb_hold > 0) tb_busy = 1'b1;
    start_job(slen, tlen);
    send_beats(slen, 1'b0, gaps, 1'b0);
    if (tbb_hold > 0) begin
      repeat (tbb_hold) begin @(posedge clk); #1; end
      chk("no_new_seq_while_tb_busy", ns_cnt, exp_ns - 1);
      tb_busy = 1'b0;
      @(negedge clk);
      chk("new_seq_low_same_cycle", new_seq, 0);
      @(negedge clk);
      chk("new_seq_cycle_after_tb_busy", new_seq, 1);
      @(posedge clk); #1;
    end
    if (drain_busy > 0) busy = 1'b1;
    send_beats(tlen, 1'b1, gaps, tog);
    if (drain_busy > 0) begin
      busy = 1'b1;
      repeat (drain_busy) begin @(posedge clk); #1; end
      chk("no_ack_while_busy", done_cnt, exp_done);
      busy = 1'b0;
    end
    exp_done++;
    wait_done();
  endtask

  initial begin
    // Reset values
    #2;
    chk("rst_s_update", s_update, 0);
    chk("rst_valid", valid, 0);
    chk("rst_new_seq", new_seq, 0);
    chk("rst_ack", ack, 0);
    chk("rst_bp_ready", bp_ready, 0);
    chk("rst_PE_end", PE_end, 0);
    chk("rst_job_ready", job_ready, 1);
    repeat (2) @(posedge clk);
    #1 reset_i = 1'b1;
    @(posedge clk); #1;

    // 1: basic job with sequential data
    run_job(4, 6, 1'b0, 1'b0, 0, 0);

    // 2: illegal lengths
    start_job(0, 5);
    @(posedge clk); #1;
    start_job(65, 5);
    repeat (3) begin @(posedge clk); #1; chk("job_ready_after_err", job_ready, 1); end
    chk("job_err_count", err_cnt, exp_err);
    chk("no_new_seq_on_err", ns_cnt, exp_ns);

    // 3: tb_busy stalls new_seq
    run_job(5, 4, 1'b0, 1'b0, 10, 0);

    // 4: busy toggling with random valid gaps
    run_job(7, 20, 1'b1, 1'b1, 0, 0);

    // 5: abort at target beat 5 of 10, then a clean job
    start_job(3, 10);
    send_beats(3, 1'b0, 1'b0, 1'b0);
    send_beats(5, 1'b1, 1'b0, 1'b0);
    abort = 1'b1;
    job_start = 1'b1;  // abort must win
    @(posedge clk); #1;
    abort = 1'b0;
    job_start = 1'b0;
    @(negedge clk);
    chk("abort_idle", job_ready, 1);
    chk("abort_valid_low", valid, 0);
    chk("abort_s_update_low", s_update, 0);
    repeat (5) begin @(posedge clk); #1; end
    chk("abort_no_done", done_cnt, exp_done);
    chk("abort_no_new_seq", ns_cnt, exp_ns);
    run_job(6, 9, 1'b1, 1'b0, 0, 0);

    // 6: full-length query, empty target, ack held off by busy
    run_job(int'(N), 0, 1'b0, 1'b0, 0, 6);

    // Reset mid-LOAD_S
    start_job(int'(N), 5);
    send_beats(10, 1'b0, 1'b0, 1'b0);
    reset_i = 1'b0;
    #1;
    chk("midrst_s_update", s_update, 0);
    chk("midrst_S", S, 0);
    chk("midrst_PE_end", PE_end, 0);
    chk("midrst_bp_ready", bp_ready, 0);
    chk("midrst_new_seq", new_seq, 0);
    chk("midrst_job_ready", job_ready, 1);
    s_exp.delete();
    pe_exp.delete();
    exp_ns--;
    @(posedge clk); #1;
    reset_i = 1'b1;
    @(posedge clk); #1;

    // Random jobs
    for (int j = 0; j < 4; j++) begin
      run_job(int'($urandom_range(1, N)), int'($urandom_range(0, 25)), 1'b1, 1'b1, 0, 0);
    end

    chk("final_err_count", err_cnt, exp_err);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
